// File: rtl/test_ts_gen_if.sv
// Payload output stream of the TS test generator.
// The master drives valid/start/end/data. The slave drives ready.
interface test_ts_gen_if;
  logic        payload_out_valid;
  logic        payload_out_ready;
  logic        payload_out_start;
  logic        payload_out_end;
  logic [15:0] payload_out_data;

  modport master (
    output payload_out_valid,
    output payload_out_start,
    output payload_out_end,
    output payload_out_data,
    input  payload_out_ready
  );

  modport slave (
    input  payload_out_valid,
    input  payload_out_start,
    input  payload_out_end,
    input  payload_out_data,
    output payload_out_ready
  );
endinterface

// File: rtl/test_ts_gen.sv
// Test TS frame generator.
// Each frame is 98 words long:
//   - a 3-word header: 8001, sequence number, length word
//   - a 188-byte MPEG-TS packet
//   - an XOR trailer word
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | no frame in progress, waiting for gen_enable
// S_HDR   | presenting header words W0..W2 (hdr_idx_q selects word)
// S_TS    | presenting TS packet words (ts_idx_q = 0..TS_WORDS-1)
// S_TRAIL | presenting XOR trailer word
// S_GAP   | inter-frame idle; gap_cnt_q counts down to 1
module test_ts_gen #(
  parameter logic [12:0] DEFAULT_PID = 13'h521,
  parameter int          TS_WORDS    = 94,
  parameter logic [15:0] LEN_WORD    = 16'h00bc
) (
  input  logic         payload_clk,
  input  logic         payload_rst,
  input  logic         gen_enable,
  input  logic [7:0]   gap_cycles,
  input  logic         inject_cc_err,
  test_ts_gen_if.master out_if,
  output logic [31:0]  frame_count,
  output logic         busy
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_TS, S_TRAIL, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  hdr_idx_q, hdr_idx_d;
  logic [6:0]  ts_idx_q, ts_idx_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] seq_q, seq_d;
  logic [3:0]  cc_q, cc_d;
  logic        pend_q, pend_d;
  logic [15:0] xor_q, xor_d;
  logic [31:0] fc_q, fc_d;

  logic        valid;
  logic        accept;
  logic        start_w;
  logic        end_w;
  logic [15:0] data_w;
  logic [15:0] ts_word;

  // TS packet word for the current index; CC is already final once W0 is accepted
  always_comb begin
    ts_word = {{ts_idx_q, 1'b0}, {ts_idx_q, 1'b1}};
    if (ts_idx_q == 7'd0) begin
      ts_word = {8'h47, 3'b000, DEFAULT_PID[12:8]};
    end else if (ts_idx_q == 7'd1) begin
      ts_word = {DEFAULT_PID[7:0], 4'b0001, cc_q};
    end
  end

  // Output word mux; outputs depend only on flops so they hold while stalled
  always_comb begin
    valid   = (state_q == S_HDR) || (state_q == S_TS) || (state_q == S_TRAIL);
    data_w  = 16'h0000;
    start_w = 1'b0;
    end_w   = 1'b0;
    case (state_q)
      S_HDR: begin
        case (hdr_idx_q)
          2'd0:    begin data_w = 16'h8001; start_w = 1'b1; end
          2'd1:    data_w = seq_q;
          default: data_w = LEN_WORD;
        endcase
      end
      S_TS:    data_w = ts_word;
      S_TRAIL: begin data_w = xor_q; end_w = 1'b1; end
      default: data_w = 16'h0000;
    endcase
  end

  assign accept                   = valid & out_if.payload_out_ready;
  assign out_if.payload_out_valid = valid;
  assign out_if.payload_out_start = start_w;
  assign out_if.payload_out_end   = end_w;
  assign out_if.payload_out_data  = data_w;
  assign frame_count              = fc_q;
  assign busy                     = valid;

  // Next-state, word counters, sequence/CC bookkeeping and trailer accumulation
  always_comb begin
    state_d   = state_q;
    hdr_idx_d = hdr_idx_q;
    ts_idx_d  = ts_idx_q;
    gap_cnt_d = gap_cnt_q;
    seq_d     = seq_q;
    cc_d      = cc_q;
    xor_d     = xor_q;
    fc_d      = fc_q;
    pend_d    = pend_q | inject_cc_err;
    case (state_q)
      S_IDLE: begin
        if (gen_enable) begin
          state_d   = S_HDR;
          hdr_idx_d = 2'd0;
        end
      end
      S_HDR: begin
        if (accept) begin
          if (hdr_idx_q == 2'd0) begin
            xor_d  = 16'h0000;
            pend_d = inject_cc_err;
            if (pend_q) cc_d = cc_q + 4'd1;
          end
          if (hdr_idx_q == 2'd2) begin
            state_d  = S_TS;
            ts_idx_d = 7'd0;
          end else begin
            hdr_idx_d = hdr_idx_q + 2'd1;
          end
        end
      end
      S_TS: begin
        if (accept) begin
          xor_d = xor_q ^ ts_word;
          if (ts_idx_q == 7'(TS_WORDS - 1)) state_d = S_TRAIL;
          else ts_idx_d = ts_idx_q + 7'd1;
        end
      end
      S_TRAIL: begin
        if (accept) begin
          fc_d      = fc_q + 32'd1;
          seq_d     = seq_q + 16'd1;
          cc_d      = cc_q + 4'd1;
          hdr_idx_d = 2'd0;
          if (gap_cycles != 8'd0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_cycles;
          end else if (gen_enable) begin
            state_d = S_HDR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - 8'd1;
        hdr_idx_d = 2'd0;
        if (gap_cnt_q == 8'd1) state_d = gen_enable ? S_HDR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight
  always_ff @(posedge payload_clk or posedge payload_rst) begin
    if (payload_rst) begin
      state_q   <= S_IDLE;
      hdr_idx_q <= 2'd0;
      ts_idx_q  <= 7'd0;
      gap_cnt_q <= 8'd0;
      seq_q     <= 16'd0;
      cc_q      <= 4'd0;
      pend_q    <= 1'b0;
      xor_q     <= 16'd0;
      fc_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      ts_idx_q  <= ts_idx_d;
      gap_cnt_q <= gap_cnt_d;
      seq_q     <= seq_d;
      cc_q      <= cc_d;
      pend_q    <= pend_d;
      xor_q     <= xor_d;
      fc_q      <= fc_d;
    end
  end

endmodule

// File: tb/tb_test_ts_gen.sv
// Bench for test_ts_gen. It keeps a frame-image model, checks every output
// cycle against it, and pins the model and key frames with literal values.
module tb_test_ts_gen;
  localparam logic [12:0] PID = 13'h521;

  logic        payload_clk = 1'b0;
  logic        payload_rst;
  logic        gen_enable;
  logic [7:0]  gap_cycles;
  logic        inject_cc_err;
  logic [31:0] frame_count;
  logic        busy;

  test_ts_gen_if bus ();

  test_ts_gen dut (
    .payload_clk   (payload_clk),
    .payload_rst   (payload_rst),
    .gen_enable    (gen_enable),
    .gap_cycles    (gap_cycles),
    .inject_cc_err (inject_cc_err),
    .out_if        (bus.master),
    .frame_count   (frame_count),
    .busy          (busy)
  );

  always #5 payload_clk = ~payload_clk;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic [15:0] exp_img [0:97];
  int          m_pos = 0;
  logic [15:0] m_seq = 16'd0;
  logic [3:0]  m_cc = 4'd0;
  logic        m_pend = 1'b0;
  logic [31:0] m_fc = 32'd0;
  int          frames_since_rst = 0;
  logic [15:0] first_w [0:97];
  logic [15:0] cc_log[$];
  logic [15:0] seq_log[$];
  int          exp_gap = -1;
  int          idle_cnt = 0;
  bit          have_end = 0;
  int          n_gap = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_data = 16'd0;
  logic        prev_start = 1'b0;
  logic        prev_end = 1'b0;
  bit          rand_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Whole frame from the frame layout rules: header, TS packet, XOR trailer
  task automatic build(input logic [15:0] seq, input logic [3:0] cc);
    logic [15:0] w;
    logic [15:0] x;
    x = 16'h0000;
    exp_img[0] = 16'h8001;
    exp_img[1] = seq;
    exp_img[2] = 16'h00bc;
    for (int k = 0; k < 94; k++) begin
      if (k == 0)      w = {8'h47, 3'b000, PID[12:8]};
      else if (k == 1) w = {PID[7:0], 4'b0001, cc};
      else begin
        w[15:8] = 8'((2 * k) % 256);
        w[7:0]  = 8'((2 * k + 1) % 256);
      end
      exp_img[3 + k] = w;
      x = x ^ w;
    end
    exp_img[97] = x;
  endtask

  // Per-cycle compare against the model, sampled on the falling edge
  always @(negedge payload_clk) begin
    if (payload_rst) begin
      check("rst_valid", {31'd0, bus.payload_out_valid}, 32'd0);
      check("rst_frame_count", frame_count, 32'd0);
      m_pos = 0; m_seq = 16'd0; m_cc = 4'd0; m_pend = 1'b0; m_fc = 32'd0;
      frames_since_rst = 0; have_end = 0; prev_stall = 0;
      cc_log.delete(); seq_log.delete();
    end else begin
      check("busy", {31'd0, busy}, {31'd0, bus.payload_out_valid});
      check("frame_count", frame_count, m_fc);
      if (prev_stall) begin
        check("stall_valid", {31'd0, bus.payload_out_valid}, 32'd1);
        check("stall_data", {16'd0, bus.payload_out_data}, {16'd0, prev_data});
        check("stall_flags", {30'd0, bus.payload_out_start, bus.payload_out_end},
              {30'd0, prev_start, prev_end});
      end
      if (bus.payload_out_valid) begin
        if (m_pos == 0) build(m_seq, m_cc + {3'b000, m_pend});
        check($sformatf("word%0d", m_pos), {16'd0, bus.payload_out_data}, {16'd0, exp_img[m_pos]});
        check("start_flag", {31'd0, bus.payload_out_start}, {31'd0, m_pos == 0});
        check("end_flag", {31'd0, bus.payload_out_end}, {31'd0, m_pos == 97});
        if (m_pos == 0 && !prev_stall && have_end) begin
          if (exp_gap >= 0) begin
            check("gap_idle_cycles", idle_cnt, exp_gap);
            n_gap++;
          end
          have_end = 0;
        end
      end else if (have_end) begin
        idle_cnt++;
      end
      if (bus.payload_out_valid && bus.payload_out_ready) begin
        if (frames_since_rst == 0) first_w[m_pos] = bus.payload_out_data;
        if (m_pos == 1) seq_log.push_back(bus.payload_out_data);
        if (m_pos == 4) cc_log.push_back(bus.payload_out_data);
        if (m_pos == 0) begin
          m_cc = m_cc + {3'b000, m_pend};
          m_pend = 1'b0;
        end
        if (m_pos == 97) begin
          m_pos = 0; m_seq++; m_cc++; m_fc++;
          have_end = 1; idle_cnt = 0; frames_since_rst++;
        end else begin
          m_pos++;
        end
      end
      prev_stall = bus.payload_out_valid && !bus.payload_out_ready;
      prev_data  = bus.payload_out_data;
      prev_start = bus.payload_out_start;
      prev_end   = bus.payload_out_end;
    end
  end

  task automatic step();
    @(posedge payload_clk);
    #1;
    if (rand_ready) bus.payload_out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_fc(input logic [31:0] target, input int budget);
    for (int i = 0; i < budget && m_fc < target; i++) step();
    check("wait_frames", {31'd0, m_fc >= target}, 32'd1);
  endtask

  task automatic wait_pos(input int p, input int budget);
    int i;
    i = 0;
    while (i < budget && !(m_pos == p && bus.payload_out_valid)) begin
      step();
      i++;
    end
    check("wait_pos", {31'd0, m_pos == p}, 32'd1);
  endtask

  initial begin
    logic [31:0] fc0;
    int vcount;
    int g0;
    payload_rst = 1'b1;
    gen_enable = 1'b1;
    gap_cycles = 8'd0;
    inject_cc_err = 1'b0;
    bus.payload_out_ready = 1'b1;

    // Literal pins on the model
    build(16'h0000, 4'h0);
    check("model_w3", {16'd0, exp_img[3]}, 32'h4705);
    check("model_w4", {16'd0, exp_img[4]}, 32'h2110);
    check("model_w5", {16'd0, exp_img[5]}, 32'h0405);
    check("model_w96", {16'd0, exp_img[96]}, 32'hBABB);

    repeat (3) step();
    payload_rst = 1'b0;

    // Three back-to-back frames
    exp_gap = 0;
    wait_fc(32'd3, 1000);
    check("fc_after_3", frame_count, 32'd3);
    check("f0_w0", {16'd0, first_w[0]}, 32'h8001);
    check("f0_w1", {16'd0, first_w[1]}, 32'h0000);
    check("f0_w2", {16'd0, first_w[2]}, 32'h00bc);
    check("f0_w3", {16'd0, first_w[3]}, 32'h4705);
    check("f0_w4", {16'd0, first_w[4]}, 32'h2110);
    check("f0_w96", {16'd0, first_w[96]}, 32'hBABB);
    check("cc_log_size", {31'd0, cc_log.size() >= 3}, 32'd1);
    if (cc_log.size() >= 3) begin
      check("cc_f0", {16'd0, cc_log[0]}, 32'h2110);
      check("cc_f1", {16'd0, cc_log[1]}, 32'h2111);
      check("cc_f2", {16'd0, cc_log[2]}, 32'h2112);
      check("seq_f1", {16'd0, seq_log[1]}, 32'h0001);
      check("seq_f2", {16'd0, seq_log[2]}, 32'h0002);
    end

    // Five-cycle inter-frame gap
    exp_gap = -1;
    gap_cycles = 8'd5;
    wait_fc(32'd4, 1000);
    exp_gap = 5;
    g0 = n_gap;
    wait_fc(32'd6, 1000);
    step();
    check("gap_checks_made", n_gap - g0, 2);

    // Random backpressure, back-to-back frames
    exp_gap = -1;
    gap_cycles = 8'd0;
    rand_ready = 1;
    wait_fc(32'd7, 2000);
    exp_gap = 0;
    wait_fc(32'd10, 3000);
    rand_ready = 0;
    bus.payload_out_ready = 1'b1;

    // Reset at TS word 40 mid-frame
    exp_gap = -1;
    wait_pos(43, 300);
    payload_rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, bus.payload_out_valid}, 32'd0);
    check("arst_data", {16'd0, bus.payload_out_data}, 32'd0);
    check("arst_flags", {30'd0, bus.payload_out_start, bus.payload_out_end}, 32'd0);
    check("arst_fc", frame_count, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    repeat (2) step();
    payload_rst = 1'b0;

    // CC corruption: two pulses during frame 1 count once
    exp_gap = 0;
    wait_fc(32'd1, 1000);
    wait_pos(50, 300);
    inject_cc_err = 1'b1; m_pend = 1'b1;
    step();
    inject_cc_err = 1'b0;
    step();
    inject_cc_err = 1'b1;
    step();
    inject_cc_err = 1'b0;
    wait_fc(32'd4, 1000);
    check("inj_log_size", {31'd0, cc_log.size() >= 4}, 32'd1);
    if (cc_log.size() >= 4) begin
      check("inj_seq0", {16'd0, seq_log[0]}, 32'h0000);
      check("inj_cc0", {16'd0, cc_log[0]}, 32'h2110);
      check("inj_cc1", {16'd0, cc_log[1]}, 32'h2111);
      check("inj_cc2", {16'd0, cc_log[2]}, 32'h2113);
      check("inj_cc3", {16'd0, cc_log[3]}, 32'h2114);
    end

    // gen_enable dropped mid-frame: frame completes, then idle
    wait_pos(20, 300);
    fc0 = m_fc;
    gen_enable = 1'b0;
    repeat (120) step();
    check("noenable_fc", frame_count, fc0 + 32'd1);
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.payload_out_valid) vcount++;
    end
    check("noenable_idle", vcount, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
